// File: rtl/dcpu16_mbus_arb.sv
// Round-robin arbiter that funnels CH requester channels onto a single master bus,
// with a per-cycle timeout that converts a missing master acknowledge into an error pulse.
module dcpu16_mbus_arb #(
    parameter int AW  = 16,
    parameter int DW  = 16,
    parameter int CH  = 2,
    parameter int TMO = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CH*AW-1:0]   c_adr,
    input  logic [CH*DW-1:0]   c_dto,
    input  logic [CH-1:0]      c_stb,
    input  logic [CH-1:0]      c_wre,
    output logic [DW-1:0]      c_dti,
    output logic [CH-1:0]      c_ack,
    output logic [CH-1:0]      c_err,
    output logic [AW-1:0]      m_adr,
    output logic [DW-1:0]      m_dto,
    output logic               m_stb,
    output logic               m_wre,
    input  logic [DW-1:0]      m_dti,
    input  logic               m_ack,
    output logic               ena
);

    localparam int GW = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [GW-1:0]   r_last;
    logic [GW-1:0]   r_grant;
    logic [7:0]      r_cnt;
    logic [AW-1:0]   r_adr;
    logic [DW-1:0]   r_dto;
    logic [DW-1:0]   r_dti;
    logic            r_stb;
    logic            r_wre;
    logic [CH-1:0]   r_ack;
    logic [CH-1:0]   r_err;

    logic [CH-1:0]   w_elig;
    logic [GW-1:0]   w_sel;
    logic            w_found;
    logic            w_tmo;
    logic            w_load;
    logic            w_fin_ack;
    logic            w_fin_err;

    // Candidate k of the round-robin scan, counting from the channel after the last grant.
    function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] last, input int k);
        int v;
        v = int'(last) + 1 + k;
        v = (v >= CH) ? (v - CH) : v;
        return GW'(v);
    endfunction

    // A channel whose pulse is showing this cycle is masked so it cannot be re-granted on a stale strobe.
    assign w_elig = c_stb & ~r_ack & ~r_err;
    assign w_tmo  = (r_cnt == TMO_LAST);
    assign ena    = ~|w_elig;

    // Round-robin pick of the first eligible channel after the last grant.
    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        for (int k = 0; k < CH; k++) begin
            if (!w_found && w_elig[rr_idx(r_last, k)]) begin
                w_sel   = rr_idx(r_last, k);
                w_found = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; an acknowledge always beats a simultaneous timeout.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = w_found ? S_BUSY : S_IDLE;
            S_BUSY:  w_state_nxt = (m_ack || w_tmo) ? S_IDLE : S_BUSY;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode: which datapath action the coming edge performs.
    always_comb begin
        w_load    = 1'b0;
        w_fin_ack = 1'b0;
        w_fin_err = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_load = w_found;
            end
            S_BUSY: begin
                w_fin_ack = m_ack;
                w_fin_err = !m_ack && w_tmo;
            end
            default: begin
                w_load = 1'b0;
            end
        endcase
    end

    // Bus datapath, completion pulses and grant history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last  <= GW'(CH - 1);
            r_grant <= '0;
            r_cnt   <= 8'd0;
            r_adr   <= '0;
            r_dto   <= '0;
            r_dti   <= '0;
            r_stb   <= 1'b0;
            r_wre   <= 1'b0;
            r_ack   <= '0;
            r_err   <= '0;
        end else begin
            r_ack <= '0;
            r_err <= '0;
            if (w_load) begin
                r_grant <= w_sel;
                r_adr   <= c_adr[int'(w_sel)*AW +: AW];
                r_dto   <= c_dto[int'(w_sel)*DW +: DW];
                r_wre   <= c_wre[w_sel];
                r_stb   <= 1'b1;
                r_cnt   <= 8'd0;
            end else if (w_fin_ack) begin
                r_stb          <= 1'b0;
                r_ack[r_grant] <= 1'b1;
                r_dti          <= r_wre ? r_dti : m_dti;
                r_last         <= r_grant;
            end else if (w_fin_err) begin
                r_stb          <= 1'b0;
                r_err[r_grant] <= 1'b1;
                r_last         <= r_grant;
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt + 8'd1;
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    assign m_adr = r_adr;
    assign m_dto = r_dto;
    assign m_stb = r_stb;
    assign m_wre = r_wre;
    assign c_ack = r_ack;
    assign c_err = r_err;
    assign c_dti = r_dti;

endmodule

// File: tb/tb_dcpu16_mbus_arb.sv
// Self-checking bench for dcpu16_mbus_arb: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_dcpu16_mbus_arb;

    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int CH  = 3;
    localparam int TMO = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [CH*AW-1:0]   c_adr;
    logic [CH*DW-1:0]   c_dto;
    logic [CH-1:0]      c_stb;
    logic [CH-1:0]      c_wre;
    logic [DW-1:0]      c_dti;
    logic [CH-1:0]      c_ack;
    logic [CH-1:0]      c_err;
    logic [AW-1:0]      m_adr;
    logic [DW-1:0]      m_dto;
    logic               m_stb;
    logic               m_wre;
    logic [DW-1:0]      m_dti;
    logic               m_ack;
    logic               ena;

    dcpu16_mbus_arb #(.AW(AW), .DW(DW), .CH(CH), .TMO(TMO)) dut (
        .clk(clk), .rst(rst),
        .c_adr(c_adr), .c_dto(c_dto), .c_stb(c_stb), .c_wre(c_wre),
        .c_dti(c_dti), .c_ack(c_ack), .c_err(c_err),
        .m_adr(m_adr), .m_dto(m_dto), .m_stb(m_stb), .m_wre(m_wre),
        .m_dti(m_dti), .m_ack(m_ack), .ena(ena)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // requester side of the model
    logic [CH-1:0]  pend, prev_pulse, always_req, p_wre;
    logic [AW-1:0]  p_adr [CH];
    logic [DW-1:0]  p_dto [CH];
    int             req_pct, force_delay;
    bit             dti_force_en;
    logic [DW-1:0]  dti_force_val;

    // bus transaction in flight and expected outputs
    bit             busy, was_stb;
    int             g, age, last, ack_delay;
    logic           exp_stb, exp_wre;
    logic [AW-1:0]  exp_adr;
    logic [DW-1:0]  exp_dto, exp_dti;
    logic [CH-1:0]  exp_ack, exp_err;

    // observation counters
    int             pulse_ack [CH];
    int             pulse_err [CH];
    int             stb_cnt, ena_hi_cnt;
    int             obs [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < CH; i++) begin
            c_stb[i]            = pend[i];
            c_wre[i]            = p_wre[i];
            c_adr[i*AW +: AW]   = p_adr[i];
            c_dto[i*DW +: DW]   = p_dto[i];
        end
    endtask

    task automatic set_req(input int ch, input logic [AW-1:0] adr, input logic [DW-1:0] dto, input logic wre);
        pend[ch]  = 1'b1;
        p_adr[ch] = adr;
        p_dto[ch] = dto;
        p_wre[ch] = wre;
    endtask

    // Random request whose top address nibble names the channel, so m_adr identifies the grant.
    task automatic new_req(input int ch);
        logic [3:0]  id;
        logic [11:0] lo;
        id = 4'(ch);
        lo = 12'($urandom);
        set_req(ch, {id, lo}, 16'($urandom), 1'($urandom));
    endtask

    task automatic clear_counters();
        for (int i = 0; i < CH; i++) begin
            pulse_ack[i] = 0;
            pulse_err[i] = 0;
        end
        stb_cnt    = 0;
        ena_hi_cnt = 0;
        obs.delete();
    endtask

    task automatic model_reset();
        pend = '0; prev_pulse = '0; p_wre = '0;
        for (int i = 0; i < CH; i++) begin
            p_adr[i] = '0;
            p_dto[i] = '0;
        end
        busy = 1'b0; was_stb = 1'b0; g = 0; age = 0; last = CH - 1; ack_delay = 0;
        exp_stb = 1'b0; exp_wre = 1'b0; exp_adr = '0; exp_dto = '0; exp_dti = '0;
        exp_ack = '0; exp_err = '0;
        always_req = '0; req_pct = 0; force_delay = -1; dti_force_en = 1'b0;
        m_ack = 1'b0; m_dti = '0;
        drive();
    endtask

    // One cycle, called just after a falling edge: compare, drive new inputs, predict the next edge.
    task automatic step();
        logic [CH-1:0] cur;
        int best, bestd, d;
        cur = exp_ack | exp_err;
        check("m_stb", m_stb, exp_stb);
        if (exp_stb) begin
            check("m_adr", m_adr, exp_adr);
            check("m_dto", m_dto, exp_dto);
            check("m_wre", m_wre, exp_wre);
            if (!was_stb) obs.push_back(int'(m_adr[15:12]));
        end
        was_stb = exp_stb;
        check("c_ack", c_ack, exp_ack);
        check("c_err", c_err, exp_err);
        check("c_dti", c_dti, exp_dti);
        for (int i = 0; i < CH; i++) begin
            if (c_ack[i]) pulse_ack[i]++;
            if (c_err[i]) pulse_err[i]++;
        end
        if (m_stb) stb_cnt++;

        for (int i = 0; i < CH; i++) begin
            if (prev_pulse[i]) pend[i] = 1'b0;
            if (!pend[i] && (always_req[i] || ($urandom_range(0, 99) < req_pct))) new_req(i);
        end
        prev_pulse = cur;
        drive();
        m_ack = (busy && age == ack_delay);
        m_dti = dti_force_en ? dti_force_val : 16'($urandom);
        #1;
        check("ena", ena, ~|(pend & ~cur));
        if (ena) ena_hi_cnt++;

        exp_ack = '0;
        exp_err = '0;
        if (busy) begin
            if (m_ack) begin
                exp_ack[g] = 1'b1;
                if (!exp_wre) exp_dti = m_dti;
                last = g; busy = 1'b0; exp_stb = 1'b0;
            end else if (age == TMO - 1) begin
                exp_err[g] = 1'b1;
                last = g; busy = 1'b0; exp_stb = 1'b0;
            end else begin
                age++;
            end
        end else begin
            best = -1;
            bestd = CH;
            for (int i = 0; i < CH; i++) begin
                if (pend[i] && !cur[i]) begin
                    d = (i - last - 1 + 2 * CH) % CH;
                    if (d < bestd) begin
                        bestd = d;
                        best = i;
                    end
                end
            end
            if (best >= 0) begin
                g = best; busy = 1'b1; age = 0; exp_stb = 1'b1;
                exp_adr = p_adr[g]; exp_dto = p_dto[g]; exp_wre = p_wre[g];
                ack_delay = (force_delay >= 0) ? force_delay : $urandom_range(0, TMO);
            end
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            step();
        end
    endtask

    // Reset with reset-value checks; returns on a falling edge with rst just released.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_m_stb_async", m_stb, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("rst_m_stb", m_stb, 1'b0);
        check("rst_m_adr", m_adr, 16'h0000);
        check("rst_m_dto", m_dto, 16'h0000);
        check("rst_m_wre", m_wre, 1'b0);
        check("rst_c_ack", c_ack, 3'b000);
        check("rst_c_err", c_err, 3'b000);
        check("rst_c_dti", c_dti, 16'h0000);
        check("rst_ena", ena, 1'b1);
        rst = 1'b0;
        clear_counters();
    endtask

    initial begin
        rst = 1'b1;
        model_reset();
        clear_counters();

        // single read on channel 0, acknowledged in the first bus cycle
        do_reset();
        set_req(0, 16'h1234, 16'h0000, 1'b0);
        force_delay = 0;
        dti_force_en = 1'b1;
        dti_force_val = 16'hBEEF;
        step();
        run(5);
        check("sr_ack0_pulses", pulse_ack[0], 1);
        check("sr_err_pulses", pulse_err[0], 0);
        check("sr_c_dti", c_dti, 16'hBEEF);

        // two channels contending continuously
        do_reset();
        always_req = 3'b011;
        step();
        run(30);
        always_req = '0;
        run(20);
        check("ct_grant_count", (obs.size() >= 4), 1'b1);
        for (int k = 0; k < 4; k++) begin
            if (k < obs.size()) check("ct_grant_order", obs[k], k % 2);
        end

        // timeout on a channel 1 write
        do_reset();
        set_req(1, 16'h1ABC, 16'h5A5A, 1'b1);
        force_delay = TMO;
        step();
        run(10);
        check("to_stb_cycles", stb_cnt, TMO);
        check("to_err1", pulse_err[1], 1);
        check("to_ack1", pulse_ack[1], 0);

        // acknowledge arriving on the last timeout cycle
        clear_counters();
        set_req(2, 16'h2F00, 16'h0000, 1'b0);
        force_delay = TMO - 1;
        step();
        run(10);
        check("col_ack2", pulse_ack[2], 1);
        check("col_err2", pulse_err[2], 0);
        check("col_stb_cycles", stb_cnt, TMO);

        // reset asserted during a bus cycle, followed by a stray acknowledge
        do_reset();
        set_req(1, 16'h1234, 16'h0000, 1'b0);
        force_delay = TMO;
        step();
        run(1);
        check("mr_stb_before", m_stb, 1'b1);
        #2;
        rst = 1'b1;
        m_ack = 1'b1;
        #1;
        check("mr_stb_async", m_stb, 1'b0);
        @(negedge clk);
        model_reset();
        m_ack = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        check("mr_late_ack", c_ack, 3'b000);
        check("mr_late_err", c_err, 3'b000);
        check("mr_late_stb", m_stb, 1'b0);
        m_ack = 1'b0;
        clear_counters();
        always_req = 3'b011;
        step();
        run(6);
        always_req = '0;
        run(20);
        check("mr_first_grant_seen", (obs.size() >= 1), 1'b1);
        if (obs.size() >= 1) check("mr_first_grant", obs[0], 0);

        // all three channels requesting: pointer wrap
        do_reset();
        always_req = 3'b111;
        step();
        run(25);
        check("wr_ena_low_cycles", ena_hi_cnt, 0);
        always_req = '0;
        run(40);
        check("wr_ena_idle", ena, 1'b1);
        check("wr_grant_count", (obs.size() >= 4), 1'b1);
        for (int k = 0; k < 4; k++) begin
            if (k < obs.size()) check("wr_grant_order", obs[k], k % 3);
        end

        // randomized traffic
        do_reset();
        req_pct = 30;
        step();
        run(3000);
        req_pct = 0;
        run(60);
        check("rnd_idle_stb", m_stb, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
